dmem_resp: RTL and testbench

DMEM_RESP -- requirements
Module: dmem_resp

---
 rtl/dmem_pkg.sv | 21 ++
 rtl/dmem_array.sv | 44 ++++
 rtl/dmem_resp.sv | 118 +++++++++++
 tb/tb_dmem_resp.sv | 199 +++++++++++++++++++
 4 files changed

// File: rtl/dmem_pkg.sv
// Shared types and defaults for the data-memory response block.
// Optional parity column is enabled by defining DMEM_PARITY_EN.
package dmem_pkg;

   localparam int unsigned DMEM_DW    = 8;
   localparam int unsigned DMEM_AW    = 8;
   localparam int unsigned DMEM_DEPTH = 256;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      RD_WAIT = 2'd1,
      RD_DONE = 2'd2,
      WR_DONE = 2'd3
   } dmem_state_e;

   // Width of a word index into an array of the given depth (minimum 1 bit).
   function automatic int unsigned idx_width(input int unsigned depth);
      return (depth > 1) ? $clog2(depth) : 1;
   endfunction

endpackage

// File: rtl/dmem_array.sv
// Word storage: one synchronous write port, one asynchronous read port.
// With DMEM_PARITY_EN defined, an even-parity column is written and checked.
module dmem_array
   import dmem_pkg::*;
#(
   parameter int unsigned DW    = DMEM_DW,
   parameter int unsigned DEPTH = DMEM_DEPTH,
   parameter int unsigned IW    = idx_width(DEPTH)
)(
   input  logic          clk,
   input  logic          we,
   input  logic [IW-1:0] waddr,
   input  logic [DW-1:0] wdata,
   input  logic [IW-1:0] raddr,
   output logic [DW-1:0] rdata,
   output logic          rpar_err
);

   logic [DW-1:0] mem [DEPTH];

   always_ff @(posedge clk) begin
      if (we) begin
         mem[waddr] <= wdata;
      end
   end

   assign rdata = mem[raddr];

`ifdef DMEM_PARITY_EN
   logic par_mem [DEPTH];

   always_ff @(posedge clk) begin
      if (we) begin
         par_mem[waddr] <= ^wdata;
      end
   end

   // Even parity: data bits plus stored parity bit must XOR to zero.
   assign rpar_err = ^{mem[raddr], par_mem[raddr]};
`else
   assign rpar_err = 1'b0;
`endif

endmodule

// File: rtl/dmem_resp.sv
// Data-memory request/response FSM: 2-cycle loads, 1-cycle stores, sticky err.
// Defining DMEM_PARITY_EN adds parity checking of loaded words.
module dmem_resp
   import dmem_pkg::*;
#(
   parameter int unsigned DW    = DMEM_DW,
   parameter int unsigned AW    = DMEM_AW,
   parameter int unsigned DEPTH = DMEM_DEPTH
)(
   input  logic          clk,
   input  logic          rst_n,
   input  logic          mem_read,
   input  logic          mem_write,
   input  logic [AW-1:0] addr,
   input  logic [DW-1:0] wdata,
   output logic [DW-1:0] rdata,
   output logic          rvalid,
   output logic          stall,
   output logic          err
);

   localparam int unsigned IW = idx_width(DEPTH);

   dmem_state_e   state;
   logic [IW-1:0] rd_idx_q;
   logic          rd_oor_q;
   logic          fwd_hit_q;
   logic [IW-1:0] wr_idx_q;
   logic          wr_ok_q;
   logic [DW-1:0] wr_data_q;

   logic          accept;
   logic          addr_ok;
   logic          do_store;
   logic          do_load;
   logic          arr_we;
   logic [IW-1:0] addr_idx;
   logic [DW-1:0] arr_rdata;
   logic          arr_perr;

   assign accept   = (state != RD_WAIT);
   assign addr_ok  = (32'(addr) < DEPTH);
   assign addr_idx = addr[IW-1:0];
   assign do_store = accept && mem_write;
   assign do_load  = accept && mem_read && !mem_write;
   assign arr_we   = do_store && addr_ok && rst_n;

   always_comb begin
      stall = (state == RD_WAIT) || do_load;
   end

   dmem_array #(
      .DW    (DW),
      .DEPTH (DEPTH),
      .IW    (IW)
   ) u_array (
      .clk      (clk),
      .we       (arr_we),
      .waddr    (addr_idx),
      .wdata    (wdata),
      .raddr    (rd_idx_q),
      .rdata    (arr_rdata),
      .rpar_err (arr_perr)
   );

   // A load accepted right after a store to the same word takes the store
   // data directly, so the result never depends on array write timing.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= IDLE;
         rdata     <= '0;
         rvalid    <= 1'b0;
         err       <= 1'b0;
         rd_idx_q  <= '0;
         rd_oor_q  <= 1'b0;
         fwd_hit_q <= 1'b0;
         wr_idx_q  <= '0;
         wr_ok_q   <= 1'b0;
         wr_data_q <= '0;
      end else begin
         rvalid <= 1'b0;
         if (state == RD_WAIT) begin
            state  <= RD_DONE;
            rvalid <= 1'b1;
            if (rd_oor_q) begin
               rdata <= '0;
            end else if (fwd_hit_q) begin
               rdata <= wr_data_q;
            end else begin
               rdata <= arr_rdata;
               if (arr_perr) begin
                  err <= 1'b1;
               end
            end
         end else if (mem_write) begin
            state     <= WR_DONE;
            wr_idx_q  <= addr_idx;
            wr_ok_q   <= addr_ok;
            wr_data_q <= wdata;
            if (mem_read || !addr_ok) begin
               err <= 1'b1;
            end
         end else if (mem_read) begin
            state     <= RD_WAIT;
            rd_idx_q  <= addr_idx;
            rd_oor_q  <= !addr_ok;
            fwd_hit_q <= (state == WR_DONE) && wr_ok_q && addr_ok &&
                         (wr_idx_q == addr_idx);
            if (!addr_ok) begin
               err <= 1'b1;
            end
         end else begin
            state <= IDLE;
         end
      end
   end

endmodule

// File: tb/tb_dmem_resp.sv
// Self-checking bench for dmem_resp: directed scenarios then random traffic
// against a cycle-level reference model of the load/store protocol.
module tb_dmem_resp;

   localparam int unsigned DW    = 8;
   localparam int unsigned AW    = 8;
   localparam int unsigned DEPTH = 128;

   logic          clk = 1'b0;
   logic          rst_n;
   logic          mem_read = 1'b0;
   logic          mem_write = 1'b0;
   logic [AW-1:0] addr = '0;
   logic [DW-1:0] wdata = '0;
   logic [DW-1:0] rdata;
   logic          rvalid;
   logic          stall;
   logic          err;

   always #5 clk = ~clk;

   dmem_resp #(.DW(DW), .AW(AW), .DEPTH(DEPTH)) u_dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .mem_read  (mem_read),
      .mem_write (mem_write),
      .addr      (addr),
      .wdata     (wdata),
      .rdata     (rdata),
      .rvalid    (rvalid),
      .stall     (stall),
      .err       (err)
   );

   int unsigned passed = 0;
   int unsigned total  = 0;
   int unsigned fails  = 0;

   // Reference model: memory image plus what the next cycle must show.
   logic [DW-1:0] mem_m   [DEPTH];
   bit            bad_par [DEPTH];
   bit            m_busy;
   bit            m_rv;
   bit            m_err;
   bit            m_pend_perr;
   logic [DW-1:0] m_rdata;
   logic [DW-1:0] m_pend;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) passed++;
      else begin
         fails++;
         $error("FAIL %s: observed %0h expected %0h at %0t", tag, obs, exp, $time);
      end
   endtask

   // Drive one cycle of inputs, check outputs mid-cycle, advance the model.
   task automatic cycle(input bit rd, input bit wr, input int unsigned a,
                        input logic [DW-1:0] d);
      bit ld, st, ok;
      mem_read  = rd;
      mem_write = wr;
      addr      = a[AW-1:0];
      wdata     = d;
      #3;
      ok = (a < DEPTH);
      st = !m_busy && wr;
      ld = !m_busy && rd && !wr;
      chk("stall", stall, m_busy || ld);
      chk("rvalid", rvalid, m_rv);
      chk("rdata", rdata, m_rdata);
      chk("err", err, m_err);
      if (m_busy) begin
         m_busy  = 1'b0;
         m_rv    = 1'b1;
         m_rdata = m_pend;
         if (m_pend_perr) m_err = 1'b1;
      end else begin
         m_rv = 1'b0;
         if (st) begin
            if (ok) begin
               mem_m[a]   = d;
               bad_par[a] = 1'b0;
            end else begin
               m_err = 1'b1;
            end
            if (rd) m_err = 1'b1;
         end else if (ld) begin
            m_busy = 1'b1;
            if (ok) begin
               m_pend      = mem_m[a];
               m_pend_perr = bad_par[a];
            end else begin
               m_pend      = '0;
               m_pend_perr = 1'b0;
               m_err       = 1'b1;
            end
         end
      end
      @(posedge clk);
      #1;
   endtask

   task automatic idle(input int unsigned n);
      for (int unsigned i = 0; i < n; i++) cycle(1'b0, 1'b0, 0, '0);
   endtask

   task automatic do_reset();
      mem_read  = 1'b0;
      mem_write = 1'b0;
      rst_n     = 1'b0;
      #1;
      chk("rst_rvalid", rvalid, 1'b0);
      chk("rst_rdata", rdata, '0);
      chk("rst_err", err, 1'b0);
      chk("rst_stall", stall, 1'b0);
      m_busy  = 1'b0;
      m_rv    = 1'b0;
      m_rdata = '0;
      m_err   = 1'b0;
      @(posedge clk);
      #1;
      rst_n = 1'b1;
   endtask

   initial begin
      rst_n = 1'b1;
      for (int unsigned i = 0; i < DEPTH; i++) bad_par[i] = 1'b0;
      @(posedge clk);
      #1;
      do_reset();

      // Fill every word so no load ever returns undefined data.
      for (int unsigned i = 0; i < DEPTH; i++) cycle(1'b0, 1'b1, i, DW'($urandom));

      // Store then immediate load of the same word.
      cycle(1'b0, 1'b1, 'h10, 8'hA5);
      cycle(1'b1, 1'b0, 'h10, '0);
      idle(2);

      // Back-to-back loads; a store driven during RD_WAIT must be ignored.
      cycle(1'b0, 1'b1, 'h01, 8'h11);
      cycle(1'b0, 1'b1, 'h02, 8'h22);
      cycle(1'b1, 1'b0, 'h01, '0);
      cycle(1'b0, 1'b1, 'h03, 8'hFF);
      cycle(1'b1, 1'b0, 'h02, '0);
      idle(2);
      cycle(1'b1, 1'b0, 'h03, '0);
      idle(2);

      // Reset in RD_WAIT aborts the load; contents survive.
      cycle(1'b1, 1'b0, 'h01, '0);
      do_reset();
      idle(2);
      cycle(1'b1, 1'b0, 'h01, '0);
      idle(2);

      // Read/write collision: store wins, load dropped, err set.
      cycle(1'b1, 1'b1, 'h05, 8'h3C);
      idle(1);
      cycle(1'b1, 1'b0, 'h05, '0);
      idle(2);

      // Out-of-range load and store; 0x90 aliases 0x10 in the low bits.
      do_reset();
      cycle(1'b1, 1'b0, 'h90, '0);
      idle(2);
      cycle(1'b0, 1'b1, 'h90, 8'h77);
      cycle(1'b1, 1'b0, 'h10, '0);
      idle(2);

`ifdef DMEM_PARITY_EN
      do_reset();
      u_dut.u_array.par_mem[7'h20] = ~u_dut.u_array.par_mem[7'h20];
      bad_par['h20] = 1'b1;
      cycle(1'b1, 1'b0, 'h20, '0);
      idle(3);
`endif

      for (int unsigned n = 0; n < 600; n++) begin
         int unsigned r;
         r = $urandom_range(0, 99);
         if (r < 2) begin
            do_reset();
         end else begin
            cycle(($urandom_range(0, 99) < 55), ($urandom_range(0, 99) < 35),
                  ($urandom_range(0, 9) == 0) ? $urandom_range(DEPTH, 255)
                                               : $urandom_range(0, DEPTH - 1),
                  DW'($urandom));
         end
      end
      idle(3);

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
